// File: rtl/rx_bcast_fifo.sv
// Receive FIFO broadcasting each stored character to two independent readers,
// with in-band XON/XOFF handling, local flow requests and sticky error flags.
module rx_bcast_fifo #(
  parameter int            DW        = 8,
  parameter int            AW        = 3,
  parameter int            HI_WM     = (2**AW) - 2,
  parameter int            LO_WM     = 2,
  parameter logic [DW-1:0] XON_CHAR  = 8'h11,
  parameter logic [DW-1:0] XOFF_CHAR = 8'h13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  input  logic          rx_parity_err,
  input  logic          rx_frame_err,
  input  logic          rx_overrun_err,
  output logic          rx_ack,
  output logic [DW-1:0] a_data,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [DW-1:0] b_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [DW-1:0] flow_char,
  output logic          flow_valid,
  input  logic          flow_ready,
  output logic          remote_xon,
  output logic [AW:0]   count,
  output logic          full,
  input  logic          err_clr,
  output logic [3:0]    led
);

  localparam int          DEPTH   = 2**AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] HI_WM_C = (AW+1)'(HI_WM);
  localparam logic [AW:0] LO_WM_C = (AW+1)'(LO_WM);

  typedef enum logic [1:0] {IDLE, SEND_XOFF, PAUSED, SEND_XON} flow_state_t;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW:0]   wp_r, ra_r, rb_r;
  logic          remote_xon_r;
  logic          rx_ack_r;
  logic [3:0]    led_r;
  flow_state_t   state_r;
  logic          flow_valid_r;
  logic [DW-1:0] flow_char_r;

  logic [AW:0]   occ_a_s, occ_b_s, count_s;
  logic          full_s, a_valid_s, b_valid_s, rd_a_s, rd_b_s;
  logic          is_xon_s, is_xoff_s, data_char_s, wr_s, ovf_s;

  function automatic logic [AW:0] max_occ(input logic [AW:0] x, input logic [AW:0] y);
    if (x > y) begin
      return x;
    end else begin
      return y;
    end
  endfunction

  // Occupancy, handshakes and character classification from pre-edge state
  always_comb begin
    occ_a_s     = wp_r - ra_r;
    occ_b_s     = wp_r - rb_r;
    count_s     = max_occ(occ_a_s, occ_b_s);
    full_s      = (count_s == DEPTH_C);
    a_valid_s   = (occ_a_s != {(AW+1){1'b0}});
    b_valid_s   = (occ_b_s != {(AW+1){1'b0}}) & remote_xon_r;
    rd_a_s      = a_valid_s & a_ready;
    rd_b_s      = b_valid_s & b_ready;
    is_xon_s    = rx_valid & ~rx_parity_err & (rx_data == XON_CHAR);
    is_xoff_s   = rx_valid & ~rx_parity_err & (rx_data == XOFF_CHAR);
    data_char_s = rx_valid & ~rx_parity_err & ~is_xon_s & ~is_xoff_s;
    wr_s        = data_char_s & ~full_s;
    ovf_s       = data_char_s & full_s;
  end

  // Character storage; cleared on reset so the read ports present zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (wr_s) begin
      mem_r[wp_r[AW-1:0]] <= rx_data;
    end
  end

  // Pointers, receiver acknowledge, remote flow state and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_r         <= {(AW+1){1'b0}};
      ra_r         <= {(AW+1){1'b0}};
      rb_r         <= {(AW+1){1'b0}};
      rx_ack_r     <= 1'b0;
      remote_xon_r <= 1'b1;
      led_r        <= 4'b0000;
    end else begin
      rx_ack_r <= rx_valid;
      if (wr_s) begin
        wp_r <= wp_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_a_s) begin
        ra_r <= ra_r + {{AW{1'b0}}, 1'b1};
      end
      if (rd_b_s) begin
        rb_r <= rb_r + {{AW{1'b0}}, 1'b1};
      end
      if (is_xoff_s) begin
        remote_xon_r <= 1'b0;
      end else if (is_xon_s) begin
        remote_xon_r <= 1'b1;
      end
      // New error events override a clear arriving in the same cycle
      led_r <= (err_clr ? 4'b0000 : led_r)
             | {ovf_s, rx_valid & rx_frame_err, rx_valid & rx_parity_err, rx_valid & rx_overrun_err};
    end
  end

  // Local XON/XOFF request; a raised request is held until the transmitter takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      flow_valid_r <= 1'b0;
      flow_char_r  <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (count_s >= HI_WM_C) begin
            state_r      <= SEND_XOFF;
            flow_valid_r <= 1'b1;
            flow_char_r  <= XOFF_CHAR;
          end
        end
        SEND_XOFF: begin
          if (flow_ready) begin
            state_r      <= PAUSED;
            flow_valid_r <= 1'b0;
            flow_char_r  <= {DW{1'b0}};
          end
        end
        PAUSED: begin
          if (count_s <= LO_WM_C) begin
            state_r      <= SEND_XON;
            flow_valid_r <= 1'b1;
            flow_char_r  <= XON_CHAR;
          end
        end
        SEND_XON: begin
          if (flow_ready) begin
            state_r      <= IDLE;
            flow_valid_r <= 1'b0;
            flow_char_r  <= {DW{1'b0}};
          end
        end
        default: begin
          state_r      <= IDLE;
          flow_valid_r <= 1'b0;
          flow_char_r  <= {DW{1'b0}};
        end
      endcase
    end
  end

  assign a_data     = mem_r[ra_r[AW-1:0]];
  assign b_data     = mem_r[rb_r[AW-1:0]];
  assign a_valid    = a_valid_s;
  assign b_valid    = b_valid_s;
  assign count      = count_s;
  assign full       = full_s;
  assign rx_ack     = rx_ack_r;
  assign remote_xon = remote_xon_r;
  assign led        = led_r;
  assign flow_valid = flow_valid_r;
  assign flow_char  = flow_char_r;

endmodule
